disp_arb_sched: RTL
===================

Name: disp_arb_sched

Overview:
- Scheduler and arbiter for the six-digit common-anode seven-segment display.
- Several requesters (time-of-day, stopwatch, alarm, ...) each present a complete pre-decoded 6-digit frame.
- This block chooses the owning requester via a mode button and an alert pre-emption FSM, applies per-digit blinking, and time-multiplexes the chosen frame onto the shared segment/enable pins with inter-digit blanking to suppress ghosting.
- Sits between the fnd_dec/frame-building logic and the board pins, replacing free-running scan logic.

Parameters:
- NUM_REQ, 3: number of requesters. Index NUM_REQ-1 is the alert requester.
- SCAN_DIV, 50000: clk cycles per digit slot (1 kHz/digit at 50 MHz).
- BLANK_CYC, 500: leading cycles of each slot with all digits off. Must be less than SCAN_DIV.
- BLINK_HALF, 500: digit slots per blink half-period (0.5 s).
- ALERT_MIN, 200: minimum frames alert ownership is held when not acknowledged.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_frame  in  NUM_REQ*42  requester k at [42k+41:42k]; digit d of a requester at [7d+6:7d], bit order {a..g}
- i_dp  in  NUM_REQ*6  requester k decimal points at [6k+5:6k]
- i_blink  in  NUM_REQ*6  requester k per-digit blink mask at [6k+5:6k]
- i_mode  in  1  one-cycle, debounced button pulse
- i_alert  in  1  level alert request from requester NUM_REQ-1
- o_seg  out  7  segments of the active digit, 1 = lit
- o_seg_dp  out  1  decimal point of the active digit
- o_seg_enb  out  6  digit enables, active-low, at most one low
- o_owner  out  $clog2(NUM_REQ)  requester currently displayed
- o_alert_act  out  1  high while in the ALERT state
- o_alert_ack  out  1  one-cycle pulse when an alert is acknowledged

Behaviour:
- Reset (asynchronous, active-high) values:
  - o_seg_enb = 6'b111111; o_seg = 0; o_seg_dp = 0; o_owner = 0; o_alert_act = 0; o_alert_ack = 0.
  - slot = 0; digit = 0; sel = 0; pend_sel = 0; blink_on = 1; armed = 1; state = NORMAL; hold = 0.
  - Reset mid-frame aborts immediately; no partial-frame state survives.
- Scan timing:
  - slot counts 0..SCAN_DIV-1 and wraps.
  - On wrap, digit advances 0..5 and wraps to 0.
  - frame_end = (slot == SCAN_DIV-1 && digit == 5).
- Output timing: all pin outputs are registered and reflect the counter state of the previous cycle (1-cycle latency).
- Blank window (slot < BLANK_CYC): o_seg_enb = 6'b111111, o_seg = 0, o_seg_dp = 0.
- Active window:
  - o_seg_enb has bit[digit] = 0 and all other bits 1.
  - o_seg and o_seg_dp come from requester o_owner, digit `digit`.
  - If that requester's blink bit for the digit is 1 and blink_on = 0: o_seg = 0 and o_seg_dp = 0, but the enable is still driven.
- Blink phase: blink_on toggles every BLINK_HALF completed digit slots. It is free-running and independent of the owner.
- Mode rotation:
  - In NORMAL, each i_mode pulse sets pend_sel = (pend_sel+1) mod NUM_REQ.
  - Multiple pulses within one frame accumulate.
  - A pulse in the frame_end cycle counts toward that boundary.
- Owner changes happen only at frame_end, so frames are never torn.
- FSM NORMAL:
  - At frame_end: sel <= pend_sel.
  - If i_alert = 1 and armed = 1: go to ALERT, set o_owner = NUM_REQ-1, clear hold. sel is preserved.
  - Otherwise: o_owner = pend_sel.
- FSM ALERT:
  - o_alert_act = 1.
  - hold increments at each frame_end and saturates at ALERT_MIN.
  - An i_mode pulse acknowledges: o_alert_ack pulses for 1 cycle, armed <= 0, exit is pending. The pulse does not rotate pend_sel.
  - At frame_end, go to NORMAL with o_owner = pend_sel if either:
    - exit is pending, or
    - i_alert = 0 and hold >= ALERT_MIN.
  - Multiple acks in one ALERT: only the first pulses o_alert_ack.
- armed returns to 1 on any cycle where i_alert = 0.
- Simultaneous i_mode pulse and alert entry in NORMAL: the rotation applies to pend_sel, the alert still pre-empts, and the rotated owner is shown after the alert exits.
- NUM_REQ = 1 is legal. Rotation is then a no-op and the alert shows requester 0.

Decomposition:
- Package disp_pkg holds:
  - DIGITS = 6; FRAME_W = 42; SEG_W = 7
  - ENB_ALL_OFF = 6'b111111; SEG_BLANK = 7'b0
  - state enum {NORMAL, ALERT}
- Sub-module scan_tick (parameters SCAN_DIV, BLANK_CYC, BLINK_HALF) outputs:
  - digit[2:0], blank, slot_end, frame_end, blink_on.
- The arbiter FSM and output mux remain in disp_arb_sched.

Test Plan (SCAN_DIV=8, BLANK_CYC=2, BLINK_HALF=6, ALERT_MIN=2, NUM_REQ=3):
- Reset release, requester 0 digits = 0..5 encoded -> per slot: 2 cycles of enb 111111 then 6 cycles of a single low bit, order 111110..011111; o_seg matches the 7'b1111110 pattern for digit 0 first; o_owner = 0.
- Two i_mode pulses mid-frame -> o_owner stays 0 until frame_end, then becomes 2; no frame mixes requesters.
- Requester 1 blink mask 6'b000001 -> digit 0 segs alternate between lit for 6 slots and 0 for 6 slots with enb still low; other digits never blank.
- i_alert rises -> at next frame_end o_owner = 2 and o_alert_act = 1; i_alert drops after 1 frame -> exit only after hold reaches 2 frames; o_owner returns to sel.
- ALERT plus i_mode pulse with i_alert held high -> o_alert_ack = 1 for 1 cycle, exit at frame_end, no re-entry while i_alert stays high; drop i_alert then re-raise -> re-enters ALERT.
- rst asserted mid-slot of digit 3 -> same-cycle enb 111111, seg 0, o_owner 0; after release the scan restarts at digit 0.

Source files
------------

// File: rtl/disp_arb_sched_pkg.sv
// +--------------------------------------------------------------------------+
// | disp_pkg: shared constants, FSM state type and digit-enable helper.       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package disp_pkg;

  localparam int DIGITS  = 6;
  localparam int FRAME_W = 42;
  localparam int SEG_W   = 7;

  localparam logic [DIGITS-1:0] ENB_ALL_OFF = 6'b111111;
  localparam logic [SEG_W-1:0]  SEG_BLANK   = 7'b0;

  typedef enum logic {
    NORMAL = 1'b0,
    ALERT  = 1'b1
  } state_t;

  // Active-low one-hot enable for a digit index.
  function automatic logic [DIGITS-1:0] digit_enb(input logic [2:0] d);
    digit_enb = ~(DIGITS'(1) << d);
  endfunction

endpackage

`default_nettype wire

// File: rtl/disp_arb_sched_scan_tick.sv
// +--------------------------------------------------------------------------+
// | scan_tick: digit-slot counter, digit index, blank window and blink phase.|
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module scan_tick
  import disp_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 500,
  parameter int BLINK_HALF = 500
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] digit,
  output logic       blank,
  output logic       slot_end,
  output logic       frame_end,
  output logic       blink_on
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [2:0] LAST_DIGIT = 3'(DIGITS - 1);

  logic [SW-1:0] slot;
  logic [BW-1:0] blink_cnt;

  assign slot_end  = (slot == SW'(SCAN_DIV - 1));
  assign frame_end = slot_end && (digit == LAST_DIGIT);
  assign blank     = (slot < SW'(BLANK_CYC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot      <= '0;
      digit     <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      slot <= slot_end ? '0 : slot + SW'(1);
      if (slot_end) begin
        digit <= (digit == LAST_DIGIT) ? '0 : digit + 3'd1;
        // Blink phase counts completed slots, independent of who owns the display.
        if (blink_cnt == BW'(BLINK_HALF - 1)) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/disp_arb_sched.sv
// +--------------------------------------------------------------------------+
// | disp_arb_sched: owner arbitration, alert pre-emption and digit scan mux. |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module disp_arb_sched
  import disp_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 500,
  parameter int BLINK_HALF = 500,
  parameter int ALERT_MIN  = 200,
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ*FRAME_W-1:0] i_frame,
  input  logic [NUM_REQ*DIGITS-1:0]  i_dp,
  input  logic [NUM_REQ*DIGITS-1:0]  i_blink,
  input  logic                       i_mode,
  input  logic                       i_alert,
  output logic [SEG_W-1:0]           o_seg,
  output logic                       o_seg_dp,
  output logic [DIGITS-1:0]          o_seg_enb,
  output logic [OW-1:0]              o_owner,
  output logic                       o_alert_act,
  output logic                       o_alert_ack
);

  localparam int HW = (ALERT_MIN > 0) ? $clog2(ALERT_MIN + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX  = HW'(ALERT_MIN);
  localparam logic [OW-1:0] ALERT_IDX = OW'(NUM_REQ - 1);

  logic [2:0] digit;
  logic       blank, slot_end, frame_end, blink_on, boundary;

  scan_tick #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC),
    .BLINK_HALF(BLINK_HALF)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .digit    (digit),
    .blank    (blank),
    .slot_end (slot_end),
    .frame_end(frame_end),
    .blink_on (blink_on)
  );

  assign boundary = slot_end & frame_end;

  logic [SEG_W-1:0]  seg_arr   [NUM_REQ][DIGITS];
  logic [DIGITS-1:0] dp_arr    [NUM_REQ];
  logic [DIGITS-1:0] blink_arr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_req
    assign dp_arr[k]    = i_dp[DIGITS*k +: DIGITS];
    assign blink_arr[k] = i_blink[DIGITS*k +: DIGITS];
    for (genvar d = 0; d < DIGITS; d++) begin : g_dig
      assign seg_arr[k][d] = i_frame[FRAME_W*k + SEG_W*d +: SEG_W];
    end
  end

  state_t         state, state_nxt;
  logic [OW-1:0]  sel, sel_nxt, pend_sel, pend_nxt, owner_nxt;
  logic [HW-1:0]  hold, hold_nxt;
  logic           armed, armed_nxt, exit_pend, exit_nxt, ack;

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    pend_nxt  = pend_sel;
    owner_nxt = o_owner;
    hold_nxt  = hold;
    armed_nxt = armed;
    exit_nxt  = exit_pend;
    ack       = 1'b0;
    case (state)
      NORMAL: begin
        if (i_mode) pend_nxt = (pend_sel == ALERT_IDX) ? '0 : pend_sel + OW'(1);
        if (boundary) begin
          sel_nxt = pend_nxt;
          if (i_alert && armed) begin
            state_nxt = ALERT;
            owner_nxt = ALERT_IDX;
            hold_nxt  = '0;
            exit_nxt  = 1'b0;
          end else begin
            owner_nxt = pend_nxt;
          end
        end
      end
      ALERT: begin
        if (i_mode && !exit_pend) begin
          ack       = 1'b1;
          exit_nxt  = 1'b1;
          armed_nxt = 1'b0;
        end
        if (boundary) begin
          // hold counts frames already shown, so the boundary that completes
          // the ALERT_MIN-th frame may release ownership.
          if (hold != HOLD_MAX) hold_nxt = hold + HW'(1);
          if (exit_nxt || (!i_alert && hold_nxt >= HOLD_MAX)) begin
            state_nxt = NORMAL;
            owner_nxt = pend_sel;
            exit_nxt  = 1'b0;
          end
        end
      end
      default: state_nxt = NORMAL;
    endcase
    if (!i_alert) armed_nxt = 1'b1;
  end

  logic [SEG_W-1:0]  seg_d;
  logic              dp_d;
  logic [DIGITS-1:0] enb_d;

  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b0;
    enb_d = ENB_ALL_OFF;
    if (!blank) begin
      enb_d = digit_enb(digit);
      if (!(blink_arr[o_owner][digit] && !blink_on)) begin
        seg_d = seg_arr[o_owner][digit];
        dp_d  = dp_arr[o_owner][digit];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= NORMAL;
      sel         <= '0;
      pend_sel    <= '0;
      hold        <= '0;
      armed       <= 1'b1;
      exit_pend   <= 1'b0;
      o_owner     <= '0;
      o_alert_ack <= 1'b0;
      o_seg       <= SEG_BLANK;
      o_seg_dp    <= 1'b0;
      o_seg_enb   <= ENB_ALL_OFF;
    end else begin
      state       <= state_nxt;
      sel         <= sel_nxt;
      pend_sel    <= pend_nxt;
      hold        <= hold_nxt;
      armed       <= armed_nxt;
      exit_pend   <= exit_nxt;
      o_owner     <= owner_nxt;
      o_alert_ack <= ack;
      o_seg       <= seg_d;
      o_seg_dp    <= dp_d;
      o_seg_enb   <= enb_d;
    end
  end

  assign o_alert_act = (state == ALERT);

endmodule

`default_nettype wire
